uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmit path (TX FIFO write port -> uart_tx) among N_REQ byte-stream clients.

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit-path arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int           DBIT_DEF     = 8;
  localparam logic [7:0]   HDR_BASE_DEF = 8'hA0;

  // Client index width; a two-client arbiter still needs one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client byte streams, TX FIFO write port and arbiter status in one bundle.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DBIT  = 8
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*DBIT-1:0] req_data;
  logic [N_REQ-1:0]      req_last;
  logic [N_REQ-1:0]      req_ready;
  logic [DBIT-1:0]       w_data;
  logic                  w_uart;
  logic                  tx_full;
  logic [N_REQ-1:0]      grant;
  logic                  busy;
  logic                  trunc;

  modport master (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, w_data, w_uart, grant, busy, trunc
  );

  modport slave (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, w_data, w_uart, grant, busy, trunc
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping mod N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
    any = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of the UART TX FIFO write port among
// N_REQ byte-stream clients, with an optional source-ID header per burst.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int              N_REQ     = 4,
  parameter int              DBIT      = DBIT_DEF,
  parameter int              MAX_BURST = 16,
  parameter int              HDR_EN    = 1,
  parameter logic [DBIT-1:0] HDR_BASE  = DBIT'(HDR_BASE_DEF)
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.master bus
);
  localparam int IW = id_width(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             trunc_q, trunc_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  logic             own_valid, own_last;
  logic [DBIT-1:0]  own_data;
  logic             xfer;
  logic             w_uart;
  logic [DBIT-1:0]  w_data;
  logic [N_REQ-1:0] req_ready;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // ptr resets to the last client so client 0 wins the first arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    trunc_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_gnt;
          id_d    = arb_idx;
          state_d = (HDR_EN != 0) ? HDR : DATA;
        end
      end
      HDR: begin
        if (w_uart) state_d = DATA;
      end
      DATA: begin
        if (xfer) begin
          if (own_last || cnt_q == CW'(MAX_BURST - 1)) begin
            state_d = IDLE;
            trunc_d = ~own_last;
            ptr_d   = id_q;
            cnt_d   = '0;
            grant_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner's stream is selected by its registered index, not by the one-hot grant.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (id_q == IW'(i)) begin
        own_valid = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_data  = bus.req_data[i*DBIT +: DBIT];
      end
    end
    xfer      = 1'b0;
    w_uart    = 1'b0;
    w_data    = '0;
    req_ready = '0;
    case (state_q)
      HDR: begin
        w_uart = ~bus.tx_full;
        w_data = HDR_BASE | DBIT'(id_q);
      end
      DATA: begin
        req_ready = grant_q & {N_REQ{~bus.tx_full}};
        xfer      = own_valid & ~bus.tx_full;
        w_uart    = xfer;
        w_data    = xfer ? own_data : '0;
      end
      default: ;
    endcase
  end

  assign bus.w_uart    = w_uart;
  assign bus.w_data    = w_data;
  assign bus.req_ready = req_ready;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.trunc     = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one header-enabled instance (A) and one
// header-disabled instance (B), with a queued byte source per client on A.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic clk;
  logic rst_a, rst_b;

  uart_tx_arbiter_if #(.N_REQ(N), .DBIT(8)) ia ();
  uart_tx_arbiter_if #(.N_REQ(N), .DBIT(8)) ib ();

  uart_tx_arbiter #(.N_REQ(N), .DBIT(8), .MAX_BURST(16), .HDR_EN(1), .HDR_BASE(8'hA0)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ia)
  );
  uart_tx_arbiter #(.N_REQ(N), .DBIT(8), .MAX_BURST(16), .HDR_EN(0), .HDR_BASE(8'hA0)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ib)
  );

  int passed = 0;
  int total  = 0;

  logic [8:0] src [N][64];
  int         wr [N];
  int         rd [N];

  logic [7:0] outq [$];
  logic [3:0] grantq [$];
  logic [7:0] outq_b [$];
  int         trunc_cnt = 0;
  int         trunc_pos = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_a();
    logic [N-1:0]   v, l;
    logic [N*8-1:0] d;
    v = '0; l = '0; d = '0;
    for (int c = 0; c < N; c++) begin
      if (rd[c] < wr[c]) begin
        v[c]         = 1'b1;
        d[c*8 +: 8]  = src[c][rd[c]][7:0];
        l[c]         = src[c][rd[c]][8];
      end
    end
    ia.req_valid = v;
    ia.req_data  = d;
    ia.req_last  = l;
  endtask

  initial begin
    ia.req_valid = '0;
    ia.req_data  = '0;
    ia.req_last  = '0;
    for (int c = 0; c < N; c++) begin
      wr[c] = 0;
      rd[c] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      drive_a();
    end
  end

  // Transfers and FIFO writes are observed mid-cycle, ahead of the committing edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < N; c++)
        if (ia.req_valid[c] && ia.req_ready[c]) rd[c]++;
      if (ia.w_uart) begin
        outq.push_back(ia.w_data);
        grantq.push_back(ia.grant);
      end
      if (ia.trunc) begin
        trunc_cnt++;
        trunc_pos = outq.size();
      end
      if (ib.w_uart) outq_b.push_back(ib.w_data);
    end
  end

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [7:0] d, input logic l);
    src[c][wr[c]] = {l, d};
    wr[c]++;
  endtask

  function automatic bit drained();
    for (int c = 0; c < N; c++)
      if (rd[c] != wr[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      nstep();
      if (ia.busy === 1'b0 && drained()) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++; if (ia.grant !== 4'b0000) $display("FAIL reset_grant got %b want 0000", ia.grant); else passed++;
    total++; if (ia.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", ia.busy); else passed++;
    total++; if (ia.trunc !== 1'b0) $display("FAIL reset_trunc got %b want 0", ia.trunc); else passed++;
    total++; if (ia.w_uart !== 1'b0) $display("FAIL reset_w_uart got %b want 0", ia.w_uart); else passed++;
    total++; if (ia.req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b want 0000", ia.req_ready); else passed++;
    total++; if (ib.grant !== 4'b0000) $display("FAIL reset_grant_b got %b want 0000", ib.grant); else passed++;
  endtask

  task automatic test_single();
    logic [7:0] exp [$];
    bit ok;
    exp = '{8'hA1, 8'h11, 8'h22, 8'h33};
    nstep();
    outq.delete(); grantq.delete();
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b1);
    nstep();
    total++; if (ia.busy !== 1'b0 || ia.w_uart !== 1'b0)
      $display("FAIL single_arb_cycle got busy=%b w_uart=%b want 0 0", ia.busy, ia.w_uart); else passed++;
    nstep();
    total++; if (ia.grant !== 4'b0010 || ia.w_uart !== 1'b1 || ia.w_data !== 8'hA1)
      $display("FAIL single_hdr_cycle got grant=%b w_uart=%b w_data=%h want 0010 1 a1", ia.grant, ia.w_uart, ia.w_data); else passed++;
    wait_done(40, ok);
    total++; if (!ok) $display("FAIL single_timeout got busy=%b want idle", ia.busy); else passed++;
    total++; if (outq.size() !== exp.size()) $display("FAIL single_count got %0d want %0d", outq.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      total++; if (outq[i] !== exp[i]) $display("FAIL single_byte%0d got %h want %h", i, outq[i], exp[i]); else passed++;
      total++; if (grantq[i] !== 4'b0010) $display("FAIL single_grant%0d got %b want 0010", i, grantq[i]); else passed++;
    end
  endtask

  task automatic test_trunc();
    logic [7:0] exp [$];
    bit ok;
    exp.push_back(8'hA3);
    for (int i = 0; i < 16; i++) exp.push_back(8'h30 + 8'(i));
    exp.push_back(8'hA3);
    for (int i = 16; i < 20; i++) exp.push_back(8'h30 + 8'(i));
    nstep();
    outq.delete(); grantq.delete(); trunc_cnt = 0; trunc_pos = 0;
    for (int i = 0; i < 20; i++) push(3, 8'h30 + 8'(i), (i == 19));
    wait_done(100, ok);
    total++; if (!ok) $display("FAIL trunc_timeout got busy=%b want idle", ia.busy); else passed++;
    total++; if (outq.size() !== exp.size()) $display("FAIL trunc_count got %0d want %0d", outq.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      total++; if (outq[i] !== exp[i]) $display("FAIL trunc_byte%0d got %h want %h", i, outq[i], exp[i]); else passed++;
    end
    total++; if (trunc_cnt !== 1) $display("FAIL trunc_pulses got %0d want 1", trunc_cnt); else passed++;
    total++; if (trunc_pos !== 17) $display("FAIL trunc_position got %0d want 17", trunc_pos); else passed++;
  endtask

  task automatic test_alternate();
    logic [7:0] exp [$];
    logic [3:0] expg [$];
    bit ok;
    exp  = '{8'hA0, 8'h01, 8'h02, 8'hA2, 8'h21, 8'h22, 8'hA0, 8'h03, 8'h04, 8'hA2, 8'h23, 8'h24};
    expg = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100,
             4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100};
    nstep();
    outq.delete(); grantq.delete(); trunc_cnt = 0;
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1); push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
    push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1); push(2, 8'h23, 1'b0); push(2, 8'h24, 1'b1);
    wait_done(100, ok);
    total++; if (!ok) $display("FAIL alt_timeout got busy=%b want idle", ia.busy); else passed++;
    total++; if (outq.size() !== exp.size()) $display("FAIL alt_count got %0d want %0d", outq.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      total++; if (outq[i] !== exp[i]) $display("FAIL alt_byte%0d got %h want %h", i, outq[i], exp[i]); else passed++;
      total++; if (grantq[i] !== expg[i]) $display("FAIL alt_grant%0d got %b want %b", i, grantq[i], expg[i]); else passed++;
    end
    total++; if (trunc_cnt !== 0) $display("FAIL alt_trunc got %0d want 0", trunc_cnt); else passed++;
  endtask

  task automatic test_tx_full();
    logic [7:0] exp [$];
    bit ok;
    exp = '{8'hA1, 8'h51, 8'h52, 8'h53, 8'h54};
    @(posedge clk); #1;
    ia.tx_full = 1'b1;
    nstep();
    outq.delete(); grantq.delete();
    push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b0); push(1, 8'h54, 1'b1);
    for (int n = 0; n < 5; n++) begin
      nstep();
      total++; if (ia.w_uart !== 1'b0 || ia.req_ready !== 4'b0000)
        $display("FAIL full_hdr_cycle%0d got w_uart=%b req_ready=%b want 0 0000", n, ia.w_uart, ia.req_ready); else passed++;
    end
    total++; if (ia.busy !== 1'b1 || ia.grant !== 4'b0010 || outq.size() !== 0)
      $display("FAIL full_hdr_hold got busy=%b grant=%b writes=%0d want 1 0010 0", ia.busy, ia.grant, outq.size()); else passed++;
    @(posedge clk); #1;
    ia.tx_full = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      nstep();
      if (outq.size() >= 3) begin ok = 1'b1; break; end
    end
    total++; if (!ok) $display("FAIL full_resume_timeout got %0d writes want 3", outq.size()); else passed++;
    @(posedge clk); #1;
    ia.tx_full = 1'b1;
    for (int n = 0; n < 5; n++) begin
      nstep();
      total++; if (ia.w_uart !== 1'b0 || ia.req_ready !== 4'b0000 || outq.size() !== 3)
        $display("FAIL full_data_cycle%0d got w_uart=%b req_ready=%b writes=%0d want 0 0000 3",
                 n, ia.w_uart, ia.req_ready, outq.size()); else passed++;
    end
    @(posedge clk); #1;
    ia.tx_full = 1'b0;
    wait_done(40, ok);
    total++; if (!ok) $display("FAIL full_timeout got busy=%b want idle", ia.busy); else passed++;
    total++; if (outq.size() !== exp.size()) $display("FAIL full_count got %0d want %0d", outq.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      total++; if (outq[i] !== exp[i]) $display("FAIL full_byte%0d got %h want %h", i, outq[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [$];
    bit ok;
    exp = '{8'hA0, 8'h70, 8'hA2, 8'h63, 8'h64, 8'h65};
    nstep();
    outq.delete(); grantq.delete();
    for (int i = 0; i < 5; i++) push(2, 8'h61 + 8'(i), (i == 4));
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      nstep();
      if (outq.size() >= 3) begin ok = 1'b1; break; end
    end
    total++; if (!ok) $display("FAIL rstmid_start_timeout got %0d writes want 3", outq.size()); else passed++;
    @(posedge clk); #1;
    rst_a = 1'b1;
    #1;
    total++; if (ia.grant !== 4'b0000 || ia.busy !== 1'b0 || ia.w_uart !== 1'b0 || ia.req_ready !== 4'b0000)
      $display("FAIL rstmid_immediate got grant=%b busy=%b w_uart=%b req_ready=%b want 0000 0 0 0000",
               ia.grant, ia.busy, ia.w_uart, ia.req_ready); else passed++;
    outq.delete(); grantq.delete();
    push(0, 8'h70, 1'b1);
    nstep();
    nstep();
    rst_a = 1'b0;
    wait_done(60, ok);
    total++; if (!ok) $display("FAIL rstmid_timeout got busy=%b want idle", ia.busy); else passed++;
    total++; if (outq.size() !== exp.size()) $display("FAIL rstmid_count got %0d want %0d", outq.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      total++; if (outq[i] !== exp[i]) $display("FAIL rstmid_byte%0d got %h want %h", i, outq[i], exp[i]); else passed++;
    end
    if (grantq.size() > 0) begin
      total++; if (grantq[0] !== 4'b0001) $display("FAIL rstmid_first_grant got %b want 0001", grantq[0]); else passed++;
    end
  endtask

  task automatic test_hold_noheader();
    logic [7:0] bytes [4];
    logic [7:0] exp [$];
    int i;
    int held;
    bytes = '{8'h81, 8'h82, 8'h83, 8'h84};
    exp   = '{8'h81, 8'h82, 8'h83, 8'h84};
    i = 0;
    held = 0;
    outq_b.delete();
    @(posedge clk); #1;
    ib.req_valid = 4'b0010; ib.req_data = {16'h0, bytes[0], 8'h0}; ib.req_last = 4'b0000;
    nstep();
    total++; if (ib.w_uart !== 1'b0 || ib.grant !== 4'b0000)
      $display("FAIL hold_arb_cycle got w_uart=%b grant=%b want 0 0000", ib.w_uart, ib.grant); else passed++;
    for (int n = 0; n < 60; n++) begin
      if (ib.req_valid[1] && ib.req_ready[1]) i++;
      if (i == 4) break;
      @(posedge clk); #1;
      if (i == 2 && held < 10) begin
        ib.req_valid = 4'b0000;
        held++;
      end else begin
        ib.req_valid = 4'b0010;
        ib.req_data  = {16'h0, bytes[i], 8'h0};
        ib.req_last  = (i == 3) ? 4'b0010 : 4'b0000;
      end
      nstep();
      if (ib.req_valid[1] === 1'b0) begin
        total++; if (ib.grant !== 4'b0010 || ib.w_uart !== 1'b0)
          $display("FAIL hold_idle_owner got grant=%b w_uart=%b want 0010 0", ib.grant, ib.w_uart); else passed++;
      end
    end
    @(posedge clk); #1;
    ib.req_valid = 4'b0000; ib.req_last = 4'b0000;
    nstep();
    total++; if (i !== 4 || held !== 10) $display("FAIL hold_progress got bytes=%0d held=%0d want 4 10", i, held); else passed++;
    total++; if (ib.grant !== 4'b0000 || ib.busy !== 1'b0)
      $display("FAIL hold_release got grant=%b busy=%b want 0000 0", ib.grant, ib.busy); else passed++;
    total++; if (outq_b.size() !== exp.size()) $display("FAIL hold_count got %0d want %0d", outq_b.size(), exp.size()); else passed++;
    for (int k = 0; k < exp.size() && k < outq_b.size(); k++) begin
      total++; if (outq_b[k] !== exp[k]) $display("FAIL hold_byte%0d got %h want %h", k, outq_b[k], exp[k]); else passed++;
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    ia.tx_full   = 1'b0;
    ib.tx_full   = 1'b0;
    ib.req_valid = '0;
    ib.req_data  = '0;
    ib.req_last  = '0;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    test_reset();
    nstep();
    nstep();
    rst_a = 1'b0;
    rst_b = 1'b0;
    test_single();
    test_trunc();
    test_alternate();
    test_tx_full();
    test_reset_mid();
    test_hold_noheader();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
